// File: rtl/adma_as_pkg.sv
// Shared constants, payload structs and the 4 KB crossing helper for the transfer fork.
// The crossing helper is only consumed when ADMA_AS_ATX_FORK_4KB_CHK_EN is defined.
package adma_as_pkg;

  localparam int unsigned ATX_BEAT_BYTES = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam int PKG_DMA_CHN_NUM = 4;
  localparam int PKG_CHN_W       = $clog2(PKG_DMA_CHN_NUM);
  localparam int PKG_MST_ID_W    = 5;
  localparam int PKG_SRC_ADDR_W  = 32;
  localparam int PKG_DST_ADDR_W  = 32;
  localparam int PKG_ATX_LEN_W   = 8;

  typedef struct packed {
    logic [PKG_MST_ID_W-1:0]   id;
    logic [PKG_SRC_ADDR_W-1:0] addr;
    logic [PKG_ATX_LEN_W-1:0]  len;
    logic [1:0]                burst;
  } atx_ar_t;

  typedef struct packed {
    logic [PKG_MST_ID_W-1:0]   id;
    logic [PKG_DST_ADDR_W-1:0] addr;
    logic [PKG_ATX_LEN_W-1:0]  len;
    logic [1:0]                burst;
  } atx_aw_t;

  typedef struct packed {
    logic [PKG_CHN_W-1:0]     chn_id;
    logic [PKG_ATX_LEN_W-1:0] len;
  } ord_ent_t;

  // True when an INCR burst starting at addr_lo runs past the end of its 4 KB page.
  function automatic logic crosses_4kb(input logic [11:0] addr_lo, input logic [15:0] len,
                                       input logic [1:0] burst);
    int unsigned end_off;
    end_off = 32'(addr_lo) + (32'(len) + 32'd1) * ATX_BEAT_BYTES;
    return (burst == BURST_INCR) && (end_off > 32'd4096);
  endfunction

endpackage

// File: rtl/adma_as_atx_fork_if.sv
// Bundle of the arbiter-side transfer port, the AXI AR/AW master ports and the W-order port.
// master = the fork itself, slave = its surroundings.
interface adma_as_atx_fork_if
  import adma_as_pkg::*;
#(
  parameter int DMA_CHN_NUM  = PKG_DMA_CHN_NUM,
  parameter int SRC_ADDR_W   = PKG_SRC_ADDR_W,
  parameter int DST_ADDR_W   = PKG_DST_ADDR_W,
  parameter int MST_ID_W     = PKG_MST_ID_W,
  parameter int ATX_LEN_W    = PKG_ATX_LEN_W,
  parameter int MAX_OUTST_RD = 8
);
  localparam int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM);
  localparam int OUTST_W       = $clog2(MAX_OUTST_RD + 1);

  logic [DMA_CHN_NUM_W-1:0] fwd_atx_chn_id;
  logic [MST_ID_W-1:0]      fwd_arid;
  logic [SRC_ADDR_W-1:0]    fwd_araddr;
  logic [ATX_LEN_W-1:0]     fwd_arlen;
  logic [1:0]               fwd_arburst;
  logic [MST_ID_W-1:0]      fwd_awid;
  logic [DST_ADDR_W-1:0]    fwd_awaddr;
  logic [ATX_LEN_W-1:0]     fwd_awlen;
  logic [1:0]               fwd_awburst;
  logic                     fwd_atx_vld;
  logic                     fwd_atx_rdy;

  logic [MST_ID_W-1:0]      m_arid;
  logic [SRC_ADDR_W-1:0]    m_araddr;
  logic [ATX_LEN_W-1:0]     m_arlen;
  logic [1:0]               m_arburst;
  logic                     m_arvalid;
  logic                     m_arready;

  logic [MST_ID_W-1:0]      m_awid;
  logic [DST_ADDR_W-1:0]    m_awaddr;
  logic [ATX_LEN_W-1:0]     m_awlen;
  logic [1:0]               m_awburst;
  logic                     m_awvalid;
  logic                     m_awready;

  logic [DMA_CHN_NUM_W-1:0] wr_ord_chn_id;
  logic [ATX_LEN_W-1:0]     wr_ord_len;
  logic                     wr_ord_vld;
  logic                     wr_ord_rdy;

  logic                     rd_done;
  logic [OUTST_W-1:0]       outst_rd;

  modport master (
    input  fwd_atx_chn_id, fwd_arid, fwd_araddr, fwd_arlen, fwd_arburst,
    input  fwd_awid, fwd_awaddr, fwd_awlen, fwd_awburst, fwd_atx_vld,
    output fwd_atx_rdy,
    output m_arid, m_araddr, m_arlen, m_arburst, m_arvalid,
    input  m_arready,
    output m_awid, m_awaddr, m_awlen, m_awburst, m_awvalid,
    input  m_awready,
    output wr_ord_chn_id, wr_ord_len, wr_ord_vld,
    input  wr_ord_rdy,
    input  rd_done,
    output outst_rd
  );

  modport slave (
    output fwd_atx_chn_id, fwd_arid, fwd_araddr, fwd_arlen, fwd_arburst,
    output fwd_awid, fwd_awaddr, fwd_awlen, fwd_awburst, fwd_atx_vld,
    input  fwd_atx_rdy,
    input  m_arid, m_araddr, m_arlen, m_arburst, m_arvalid,
    output m_arready,
    input  m_awid, m_awaddr, m_awlen, m_awburst, m_awvalid,
    output m_awready,
    input  wr_ord_chn_id, wr_ord_len, wr_ord_vld,
    output wr_ord_rdy,
    output rd_done,
    input  outst_rd
  );

endinterface

// File: rtl/adma_as_atx_fifo.sv
// Synchronous FIFO with a registered head: an entry pushed into an empty queue is visible
// at the head one cycle later. DEPTH must be a power of two so the pointers wrap naturally.
module adma_as_atx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              nonempty,
  output logic              full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic [DATA_W-1:0] head_reg;
  logic              push_ok;
  logic              pop_ok;
  logic              left_empty;

  assign nonempty    = (cnt_reg != '0);
  assign full        = (cnt_reg == CNT_W'(DEPTH));
  assign push_ok     = push & ~full;
  assign pop_ok      = pop & nonempty;
  assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop_ok);
  assign cnt_next    = cnt_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
  assign left_empty  = ((cnt_reg - CNT_W'(pop_ok)) == '0);
  assign head        = head_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Head follows the next read pointer; a push into a drained queue bypasses storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_ok);
      rd_ptr_reg <= rd_ptr_next;
      cnt_reg    <= cnt_next;
      if (left_empty) begin
        if (push_ok) begin
          head_reg <= push_data;
        end
      end else begin
        head_reg <= mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/adma_as_atx_fork.sv
// Forks each arbitrated transfer into AR, AW and W-order queues and gates AR issue by an
// outstanding-read limit. Optional 4 KB crossing flag under ADMA_AS_ATX_FORK_4KB_CHK_EN.
module adma_as_atx_fork
  import adma_as_pkg::*;
#(
  parameter int DMA_CHN_NUM  = PKG_DMA_CHN_NUM,
  parameter int SRC_ADDR_W   = PKG_SRC_ADDR_W,
  parameter int DST_ADDR_W   = PKG_DST_ADDR_W,
  parameter int MST_ID_W     = PKG_MST_ID_W,
  parameter int ATX_LEN_W    = PKG_ATX_LEN_W,
  parameter int Q_DEPTH      = 4,
  parameter int MAX_OUTST_RD = 8
) (
  input logic                clk,
  input logic                rst,
  adma_as_atx_fork_if.master bus
`ifdef ADMA_AS_ATX_FORK_4KB_CHK_EN
  ,
  output logic               bnd_err
`endif
);
  localparam int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM);
  localparam int OUTST_W       = $clog2(MAX_OUTST_RD + 1);
  localparam int AR_W          = MST_ID_W + SRC_ADDR_W + ATX_LEN_W + 2;
  localparam int AW_W          = MST_ID_W + DST_ADDR_W + ATX_LEN_W + 2;
  localparam int ORD_W         = DMA_CHN_NUM_W + ATX_LEN_W;

  logic [AR_W-1:0]    ar_head;
  logic [AW_W-1:0]    aw_head;
  logic [ORD_W-1:0]   ord_head;
  logic               ar_nonempty, ar_full;
  logic               aw_nonempty, aw_full;
  logic               ord_nonempty, ord_full;
  logic               accept;
  logic               ar_hs;
  logic               aw_hs;
  logic               ord_hs;
  logic               rd_dec;
  logic [OUTST_W-1:0] outst_reg;

  assign bus.fwd_atx_rdy = ~ar_full & ~aw_full & ~ord_full;
  assign accept          = bus.fwd_atx_vld & bus.fwd_atx_rdy;

  assign ar_hs  = bus.m_arvalid & bus.m_arready;
  assign aw_hs  = bus.m_awvalid & bus.m_awready;
  assign ord_hs = bus.wr_ord_vld & bus.wr_ord_rdy;

  adma_as_atx_fifo #(.DATA_W(AR_W), .DEPTH(Q_DEPTH)) u_ar_q (
    .clk(clk), .rst(rst), .push(accept),
    .push_data({bus.fwd_arid, bus.fwd_araddr, bus.fwd_arlen, bus.fwd_arburst}),
    .pop(ar_hs), .head(ar_head), .nonempty(ar_nonempty), .full(ar_full)
  );

  adma_as_atx_fifo #(.DATA_W(AW_W), .DEPTH(Q_DEPTH)) u_aw_q (
    .clk(clk), .rst(rst), .push(accept),
    .push_data({bus.fwd_awid, bus.fwd_awaddr, bus.fwd_awlen, bus.fwd_awburst}),
    .pop(aw_hs), .head(aw_head), .nonempty(aw_nonempty), .full(aw_full)
  );

  adma_as_atx_fifo #(.DATA_W(ORD_W), .DEPTH(Q_DEPTH)) u_ord_q (
    .clk(clk), .rst(rst), .push(accept),
    .push_data({bus.fwd_atx_chn_id, bus.fwd_awlen}),
    .pop(ord_hs), .head(ord_head), .nonempty(ord_nonempty), .full(ord_full)
  );

  // outst_reg only rises on an AR handshake, so a held m_arvalid can never be withdrawn.
  assign bus.m_arvalid = ar_nonempty & (outst_reg < OUTST_W'(MAX_OUTST_RD));
  assign {bus.m_arid, bus.m_araddr, bus.m_arlen, bus.m_arburst} = ar_head;

  assign bus.m_awvalid = aw_nonempty;
  assign {bus.m_awid, bus.m_awaddr, bus.m_awlen, bus.m_awburst} = aw_head;

  assign bus.wr_ord_vld = ord_nonempty;
  assign {bus.wr_ord_chn_id, bus.wr_ord_len} = ord_head;

  assign rd_dec       = bus.rd_done & (outst_reg != '0);
  assign bus.outst_rd = outst_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      outst_reg <= '0;
    end else begin
      outst_reg <= outst_reg + OUTST_W'(ar_hs) - OUTST_W'(rd_dec);
    end
  end

`ifdef ADMA_AS_ATX_FORK_4KB_CHK_EN
  logic bnd_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      bnd_err_reg <= 1'b0;
    end else if (accept &&
                 (crosses_4kb(bus.fwd_araddr[11:0], 16'(bus.fwd_arlen), bus.fwd_arburst) ||
                  crosses_4kb(bus.fwd_awaddr[11:0], 16'(bus.fwd_awlen), bus.fwd_awburst))) begin
      bnd_err_reg <= 1'b1;
    end
  end

  assign bnd_err = bnd_err_reg;
`endif

endmodule

// File: tb/tb_adma_as_atx_fork.sv
// Bench for adma_as_atx_fork: vector table, hand sequences for backpressure, read limit and
// reset, then random traffic against a queue-based model. Define ADMA_AS_ATX_FORK_4KB_CHK_EN to cover bnd_err.
module tb_adma_as_atx_fork;
  import adma_as_pkg::*;

  typedef struct {
    logic [1:0] chn;
    atx_ar_t    ar;
    atx_aw_t    aw;
    logic       bnd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adma_as_atx_fork_if bus_if ();
`ifdef ADMA_AS_ATX_FORK_4KB_CHK_EN
  logic bnd_err;
`endif

  adma_as_atx_fork dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
`ifdef ADMA_AS_ATX_FORK_4KB_CHK_EN
    ,
    .bnd_err(bnd_err)
`endif
  );

  int vec_cnt = 0;
  int miscmp  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic [1:0] chn, logic [4:0] arid, logic [31:0] araddr,
                              logic [7:0] arlen, logic [1:0] arb, logic [4:0] awid,
                              logic [31:0] awaddr, logic [7:0] awlen, logic [1:0] awb, logic bnd);
    vec_t v;
    v.chn = chn;
    v.ar  = '{id: arid, addr: araddr, len: arlen, burst: arb};
    v.aw  = '{id: awid, addr: awaddr, len: awlen, burst: awb};
    v.bnd = bnd;
    return v;
  endfunction

  function automatic bit model_cross(logic [31:0] addr, logic [7:0] len, logic [1:0] burst);
    int unsigned page_off;
    page_off = addr % 4096;
    return (burst == BURST_INCR) && (page_off + (int'(len) + 1) * ATX_BEAT_BYTES > 4096);
  endfunction

  function automatic atx_ar_t cur_ar();
    return '{id: bus_if.m_arid, addr: bus_if.m_araddr, len: bus_if.m_arlen, burst: bus_if.m_arburst};
  endfunction

  function automatic atx_aw_t cur_aw();
    return '{id: bus_if.m_awid, addr: bus_if.m_awaddr, len: bus_if.m_awlen, burst: bus_if.m_awburst};
  endfunction

  task automatic drive(input vec_t v);
    bus_if.fwd_atx_chn_id = v.chn;
    bus_if.fwd_arid       = v.ar.id;
    bus_if.fwd_araddr     = v.ar.addr;
    bus_if.fwd_arlen      = v.ar.len;
    bus_if.fwd_arburst    = v.ar.burst;
    bus_if.fwd_awid       = v.aw.id;
    bus_if.fwd_awaddr     = v.aw.addr;
    bus_if.fwd_awlen      = v.aw.len;
    bus_if.fwd_awburst    = v.aw.burst;
  endtask

  task automatic rd_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      bus_if.rd_done = 1'b1;
      cyc();
      bus_if.rd_done = 1'b0;
    end
  endtask

  vec_t tbl[4];
  vec_t bp[4];

  // Reference model state for the random phase.
  atx_ar_t  ar_q[$];
  atx_aw_t  aw_q[$];
  ord_ent_t ord_q[$];
  int       outst_m;
  bit       bnd_m;

  initial begin
    int hs;
    int pushed;
    bit acc;

    tbl[0] = mk(2'd2, 5'd1,  32'h0000_1000, 8'd3,   BURST_INCR,  5'd2, 32'h0000_8000, 8'd3,   BURST_INCR, 1'b0);
    tbl[1] = mk(2'd0, 5'd31, 32'h0000_0FF0, 8'd1,   BURST_INCR,  5'd0, 32'h0000_2000, 8'd0,   BURST_FIXED, 1'b0);
    tbl[2] = mk(2'd3, 5'd5,  32'h0000_0FF0, 8'd3,   BURST_INCR,  5'd7, 32'h0000_4000, 8'd15,  BURST_INCR, 1'b1);
    tbl[3] = mk(2'd1, 5'd9,  32'h0000_3000, 8'd255, BURST_FIXED, 5'd3, 32'hFFFF_F800, 8'd255, BURST_INCR, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bp[i] = mk(2'(i), 5'(i + 4), 32'h100 * i, 8'(i), BURST_INCR,
                 5'(i + 8), 32'hA000 + 32'h40 * i, 8'(i + 1), BURST_INCR, 1'b0);
    end

    bus_if.fwd_atx_vld = 1'b0;
    bus_if.m_arready   = 1'b0;
    bus_if.m_awready   = 1'b0;
    bus_if.wr_ord_rdy  = 1'b0;
    bus_if.rd_done     = 1'b0;
    drive(mk(2'd0, 5'd0, 32'd0, 8'd0, 2'd0, 5'd0, 32'd0, 8'd0, 2'd0, 1'b0));

    // Reset state
    repeat (2) cyc();
    chk("rst_arvalid", 64'(bus_if.m_arvalid), 64'd0);
    chk("rst_awvalid", 64'(bus_if.m_awvalid), 64'd0);
    chk("rst_ordvld", 64'(bus_if.wr_ord_vld), 64'd0);
    chk("rst_outst", 64'(bus_if.outst_rd), 64'd0);
    chk("rst_araddr", 64'(bus_if.m_araddr), 64'd0);
    rst = 1'b0;
    cyc();
    chk("rst_rdy", 64'(bus_if.fwd_atx_rdy), 64'd1);

    // Vector table: one transfer at a time, both AXI readies high
    bus_if.m_arready = 1'b1;
    bus_if.m_awready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i]);
      bus_if.fwd_atx_vld = 1'b1;
      chk("vec_rdy", 64'(bus_if.fwd_atx_rdy), 64'd1);
      cyc();
      bus_if.fwd_atx_vld = 1'b0;
      chk("vec_arvalid", 64'(bus_if.m_arvalid), 64'd1);
      chk("vec_ar", 64'(cur_ar()), 64'(tbl[i].ar));
      chk("vec_awvalid", 64'(bus_if.m_awvalid), 64'd1);
      chk("vec_aw", 64'(cur_aw()), 64'(tbl[i].aw));
      chk("vec_ordvld", 64'(bus_if.wr_ord_vld), 64'd1);
      chk("vec_ord", 64'({bus_if.wr_ord_chn_id, bus_if.wr_ord_len}), 64'({tbl[i].chn, tbl[i].aw.len}));
      chk("vec_outst0", 64'(bus_if.outst_rd), 64'd0);
`ifdef ADMA_AS_ATX_FORK_4KB_CHK_EN
      chk("vec_bnd", 64'(bnd_err), 64'(tbl[i].bnd));
`endif
      bus_if.wr_ord_rdy = 1'b1;
      cyc();
      bus_if.wr_ord_rdy = 1'b0;
      chk("vec_outst1", 64'(bus_if.outst_rd), 64'd1);
      chk("vec_drained", 64'({bus_if.m_arvalid, bus_if.m_awvalid, bus_if.wr_ord_vld}), 64'd0);
      rd_pulses(1);
      chk("vec_outst_ret", 64'(bus_if.outst_rd), 64'd0);
    end

    // AW backpressure fills the AW queue while AR keeps draining
    bus_if.m_awready  = 1'b0;
    bus_if.wr_ord_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(bp[i]);
      bus_if.fwd_atx_vld = 1'b1;
      chk("bp_rdy_open", 64'(bus_if.fwd_atx_rdy), 64'd1);
      cyc();
    end
    bus_if.fwd_atx_vld = 1'b0;
    chk("bp_rdy_full", 64'(bus_if.fwd_atx_rdy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_aw_held_vld", 64'(bus_if.m_awvalid), 64'd1);
      chk("bp_aw_held", 64'(cur_aw()), 64'(bp[0].aw));
    end
    chk("bp_ar_drained", 64'(bus_if.m_arvalid), 64'd0);
    chk("bp_outst", 64'(bus_if.outst_rd), 64'd4);
    bus_if.m_awready = 1'b1;
    cyc();
    chk("bp_rdy_restore", 64'(bus_if.fwd_atx_rdy), 64'd1);
    chk("bp_aw_next", 64'(cur_aw()), 64'(bp[1].aw));
    repeat (3) cyc();
    chk("bp_aw_empty", 64'(bus_if.m_awvalid), 64'd0);
    rd_pulses(4);
    chk("bp_outst_ret", 64'(bus_if.outst_rd), 64'd0);

    // Outstanding-read limit: 10 transfers, no rd_done
    hs = 0;
    pushed = 0;
    for (int k = 0; k < 60; k++) begin
      bus_if.fwd_atx_vld = (pushed < 10);
      drive(tbl[pushed % 4]);
      acc = bus_if.fwd_atx_vld & bus_if.fwd_atx_rdy;
      hs += int'(bus_if.m_arvalid & bus_if.m_arready);
      cyc();
      if (acc) pushed++;
    end
    bus_if.fwd_atx_vld = 1'b0;
    chk("lim_pushed", 64'(pushed), 64'd10);
    chk("lim_hs", 64'(hs), 64'd8);
    chk("lim_arvalid", 64'(bus_if.m_arvalid), 64'd0);
    chk("lim_outst", 64'(bus_if.outst_rd), 64'd8);
    hs = 0;
    for (int k = 0; k < 6; k++) begin
      bus_if.rd_done = (k == 0);
      hs += int'(bus_if.m_arvalid & bus_if.m_arready);
      cyc();
    end
    bus_if.rd_done = 1'b0;
    chk("lim_one_more", 64'(hs), 64'd1);

    // AR handshake and rd_done in the same cycle at outst_rd=5
    bus_if.m_arready = 1'b0;
    rd_pulses(3);
    chk("sim_outst5", 64'(bus_if.outst_rd), 64'd5);
    chk("sim_arvalid", 64'(bus_if.m_arvalid), 64'd1);
    bus_if.m_arready = 1'b1;
    bus_if.rd_done   = 1'b1;
    cyc();
    bus_if.rd_done = 1'b0;
    chk("sim_outst_hold", 64'(bus_if.outst_rd), 64'd5);
    rd_pulses(5);
    chk("sim_outst_ret", 64'(bus_if.outst_rd), 64'd0);

    // Reset with entries queued and m_arvalid high
    bus_if.m_arready  = 1'b0;
    bus_if.m_awready  = 1'b0;
    bus_if.wr_ord_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(bp[i]);
      bus_if.fwd_atx_vld = 1'b1;
      cyc();
    end
    bus_if.fwd_atx_vld = 1'b0;
    bus_if.m_arready = 1'b1;
    cyc();
    bus_if.m_arready = 1'b0;
    chk("mrst_pre_arvalid", 64'(bus_if.m_arvalid), 64'd1);
    chk("mrst_pre_outst", 64'(bus_if.outst_rd), 64'd1);
    rst = 1'b1;
    cyc();
    chk("mrst_valids", 64'({bus_if.m_arvalid, bus_if.m_awvalid, bus_if.wr_ord_vld}), 64'd0);
    chk("mrst_outst", 64'(bus_if.outst_rd), 64'd0);
    chk("mrst_araddr", 64'(bus_if.m_araddr), 64'd0);
    rst = 1'b0;
    cyc();
    chk("mrst_rdy", 64'(bus_if.fwd_atx_rdy), 64'd1);
    chk("mrst_empty", 64'({bus_if.m_arvalid, bus_if.m_awvalid, bus_if.wr_ord_vld}), 64'd0);
    bus_if.m_arready  = 1'b1;
    bus_if.m_awready  = 1'b1;
    bus_if.wr_ord_rdy = 1'b1;
    drive(tbl[0]);
    bus_if.fwd_atx_vld = 1'b1;
    cyc();
    bus_if.fwd_atx_vld = 1'b0;
    chk("mrst_new_ar", 64'(cur_ar()), 64'(tbl[0].ar));
    chk("mrst_new_ord", 64'({bus_if.wr_ord_chn_id, bus_if.wr_ord_len}), 64'({tbl[0].chn, tbl[0].aw.len}));
    cyc();
    chk("mrst_new_outst", 64'(bus_if.outst_rd), 64'd1);

    // Random traffic against the queue model, from a fresh reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    outst_m = 0;
    bnd_m   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bit exp_rdy, exp_arv, exp_awv, exp_ordv, arhs, awhs, ordhs, rdd;
      vec_t v;
      exp_rdy  = (ar_q.size() < 4) && (aw_q.size() < 4) && (ord_q.size() < 4);
      exp_arv  = (ar_q.size() > 0) && (outst_m < 8);
      exp_awv  = (aw_q.size() > 0);
      exp_ordv = (ord_q.size() > 0);
      chk("rnd_rdy", 64'(bus_if.fwd_atx_rdy), 64'(exp_rdy));
      chk("rnd_arvalid", 64'(bus_if.m_arvalid), 64'(exp_arv));
      chk("rnd_awvalid", 64'(bus_if.m_awvalid), 64'(exp_awv));
      chk("rnd_ordvld", 64'(bus_if.wr_ord_vld), 64'(exp_ordv));
      chk("rnd_outst", 64'(bus_if.outst_rd), 64'(outst_m));
      if (exp_arv) chk("rnd_ar", 64'(cur_ar()), 64'(ar_q[0]));
      if (exp_awv) chk("rnd_aw", 64'(cur_aw()), 64'(aw_q[0]));
      if (exp_ordv) chk("rnd_ord", 64'({bus_if.wr_ord_chn_id, bus_if.wr_ord_len}), 64'(ord_q[0]));
`ifdef ADMA_AS_ATX_FORK_4KB_CHK_EN
      chk("rnd_bnd", 64'(bnd_err), 64'(bnd_m));
`endif

      v = mk(2'($urandom_range(0, 3)), 5'($urandom), $urandom, 8'($urandom), 2'($urandom_range(0, 1)),
             5'($urandom), $urandom, 8'($urandom), 2'($urandom_range(0, 1)), 1'b0);
      drive(v);
      bus_if.fwd_atx_vld = ($urandom_range(0, 3) != 0);
      bus_if.m_arready   = ($urandom_range(0, 3) != 0);
      bus_if.m_awready   = ($urandom_range(0, 2) != 0);
      bus_if.wr_ord_rdy  = ($urandom_range(0, 2) != 0);
      rdd = (i < 200) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 0);
      bus_if.rd_done = rdd;

      arhs  = exp_arv && bus_if.m_arready;
      awhs  = exp_awv && bus_if.m_awready;
      ordhs = exp_ordv && bus_if.wr_ord_rdy;
      if (arhs) void'(ar_q.pop_front());
      if (awhs) void'(aw_q.pop_front());
      if (ordhs) void'(ord_q.pop_front());
      if (bus_if.fwd_atx_vld && exp_rdy) begin
        ar_q.push_back(v.ar);
        aw_q.push_back(v.aw);
        ord_q.push_back('{chn_id: v.chn, len: v.aw.len});
        if (model_cross(v.ar.addr, v.ar.len, v.ar.burst) ||
            model_cross(v.aw.addr, v.aw.len, v.aw.burst)) bnd_m = 1'b1;
      end
      outst_m = outst_m + (arhs ? 1 : 0) - ((rdd && outst_m > 0) ? 1 : 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
